pipeline_skid_reg: RTL and testbench

PIPELINE_SKID_REG -- requirements
Module: pipeline_skid_reg

---
 rtl/pipeline_skid_reg.sv | 123 ++++++++++++
 tb/tb_pipeline_skid_reg.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_skid_reg.sv
// Two-entry skid buffer pipeline stage.
// Breaks the combinational ready path between downstream and upstream: in_ready
// depends only on registered state, and the skid register catches the one word
// that may arrive in the cycle downstream stalls. A wrapping counter tracks
// completed output transfers. flush empties the stage without touching the
// stored data words.
module pipeline_skid_reg #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] pipeline_out,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             flush,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] xfer_count
);

    // The encoding equals the number of held entries, so occupancy is a direct copy.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic [CNT_W-1:0] xfer_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [1:0]       occupancy_q;

    logic             in_fire;
    logic             out_fire;
    logic             load_main_in;
    logic             load_main_skid;
    logic             load_skid;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid_q & out_ready;

    // Next-state and data-steering decision; flush overrides every handshake move.
    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state_nxt    = ONE;
                        load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        load_main_in = 1'b1;
                    end else if (in_fire) begin
                        state_nxt = FULL;
                        load_skid = 1'b1;
                    end else if (out_fire) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state_nxt      = ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                end
            endcase
        end
    end

    // State, data registers, transfer counter and registered status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            xfer_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            occupancy_q <= 2'd0;
        end else begin
            state       <= state_nxt;
            in_ready_q  <= (state_nxt != FULL);
            out_valid_q <= (state_nxt != EMPTY);
            occupancy_q <= state_nxt;
            if (load_main_in) begin
                main_q <= in_data;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
            if (out_fire) begin
                xfer_q <= xfer_q + CNT_W'(1);
            end
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign occupancy    = occupancy_q;
    assign pipeline_out = main_q;
    assign xfer_count   = xfer_q;

endmodule

// File: tb/tb_pipeline_skid_reg.sv
// Self-checking bench for pipeline_skid_reg.
// A queue-based model of the stage runs alongside two DUT instances (default
// counter width and a 2-bit counter) and is compared on every falling edge.
// Directed sequences add literal expectations that pin the model itself.
module tb_pipeline_skid_reg;

    logic        clk;
    logic        reset;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] pipeline_out;
    logic        out_valid;
    logic        out_ready;
    logic        flush;
    logic [1:0]  occupancy;
    logic [7:0]  xfer_count;

    logic        in_ready2;
    logic [15:0] pipeline_out2;
    logic        out_valid2;
    logic [1:0]  occupancy2;
    logic [1:0]  xfer_count2;

    int checks;
    int failures;

    pipeline_skid_reg #(.WIDTH(16), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .pipeline_out(pipeline_out), .out_valid(out_valid),
        .out_ready(out_ready), .flush(flush), .occupancy(occupancy),
        .xfer_count(xfer_count)
    );

    pipeline_skid_reg #(.WIDTH(16), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready2), .pipeline_out(pipeline_out2), .out_valid(out_valid2),
        .out_ready(out_ready), .flush(flush), .occupancy(occupancy2),
        .xfer_count(xfer_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the held entries as a FIFO queue, the visible word, and a transfer count.
    logic [15:0] mq[$];
    logic [15:0] m_held;
    int          m_cnt;
    bit          m_ok;
    bit          m_in_fire;
    bit          m_out_fire;

    initial begin
        m_ok   = 1'b0;
        m_held = '0;
        m_cnt  = 0;
    end

    // Model update on each rising edge from the stage's rules.
    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            m_held = '0;
            m_cnt  = 0;
            m_ok   = 1'b1;
        end else if (m_ok) begin
            m_out_fire = (mq.size() > 0) && out_ready;
            m_in_fire  = in_valid && (mq.size() < 2);
            if (m_out_fire) m_cnt = m_cnt + 1;
            if (flush) begin
                mq.delete();
            end else begin
                if (m_out_fire) void'(mq.pop_front());
                if (m_in_fire) mq.push_back(in_data);
            end
            if (mq.size() > 0) m_held = mq[0];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks = checks + 1;
        if (actual !== expected) begin
            failures = failures + 1;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        logic [31:0] cnt_v;
        if (m_ok) begin
            cnt_v = m_cnt;
            checkOutput("model_in_ready", {31'd0, in_ready}, {31'd0, (mq.size() < 2)});
            checkOutput("model_out_valid", {31'd0, out_valid}, {31'd0, (mq.size() > 0)});
            checkOutput("model_occupancy", {30'd0, occupancy}, mq.size());
            checkOutput("model_pipeline_out", {16'd0, pipeline_out}, {16'd0, m_held});
            checkOutput("model_xfer_count", {24'd0, xfer_count}, {24'd0, cnt_v[7:0]});
            checkOutput("model_xfer_count_w2", {30'd0, xfer_count2}, {30'd0, cnt_v[1:0]});
            checkOutput("model_pipeline_out_w2", {16'd0, pipeline_out2}, {16'd0, m_held});
        end
    end

    // Present inputs for the next rising edge, then step just past that edge.
    task automatic applyStimulus(input logic rst, input logic fl, input logic iv,
                                 input logic [15:0] din, input logic ordy);
        reset     = rst;
        flush     = fl;
        in_valid  = iv;
        in_data   = din;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] cnt_seq[5];
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        flush    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset state and single-word latency.
        applyStimulus(1, 0, 0, 16'h0000, 0);
        checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_occupancy", {30'd0, occupancy}, 32'd0);
        checkOutput("reset_pipeline_out", {16'd0, pipeline_out}, 32'd0);
        applyStimulus(0, 0, 1, 16'h1234, 1);
        checkOutput("lat_pipeline_out", {16'd0, pipeline_out}, 32'h1234);
        checkOutput("lat_out_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("lat_occupancy", {30'd0, occupancy}, 32'd1);
        applyStimulus(0, 0, 0, 16'h0000, 1);
        checkOutput("lat_drain_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("lat_xfer_count", {24'd0, xfer_count}, 32'd1);

        // Fill to FULL under backpressure, then drain in order.
        applyStimulus(1, 0, 0, 16'h0000, 0);
        applyStimulus(0, 0, 1, 16'h000A, 0);
        applyStimulus(0, 0, 1, 16'h000B, 0);
        checkOutput("full_occupancy", {30'd0, occupancy}, 32'd2);
        checkOutput("full_in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("full_pipeline_out", {16'd0, pipeline_out}, 32'h000A);
        applyStimulus(0, 0, 1, 16'h000C, 0);
        checkOutput("stall_pipeline_out", {16'd0, pipeline_out}, 32'h000A);
        applyStimulus(0, 0, 0, 16'h0000, 1);
        checkOutput("drain1_pipeline_out", {16'd0, pipeline_out}, 32'h000B);
        checkOutput("drain1_occupancy", {30'd0, occupancy}, 32'd1);
        applyStimulus(0, 0, 0, 16'h0000, 1);
        checkOutput("drain2_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("drain2_held_out", {16'd0, pipeline_out}, 32'h000B);
        checkOutput("drain2_xfer_count", {24'd0, xfer_count}, 32'd2);

        // Sustained streaming with no bubbles.
        applyStimulus(1, 0, 0, 16'h0000, 0);
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(0, 0, 1, 16'(i), 1);
            checkOutput("stream_pipeline_out", {16'd0, pipeline_out}, i);
            checkOutput("stream_occupancy", {30'd0, occupancy}, 32'd1);
        end
        applyStimulus(0, 0, 0, 16'h0000, 1);
        checkOutput("stream_xfer_count", {24'd0, xfer_count}, 32'd16);
        checkOutput("stream_end_out_valid", {31'd0, out_valid}, 32'd0);

        // Flush from FULL while a new word is offered.
        applyStimulus(1, 0, 0, 16'h0000, 0);
        applyStimulus(0, 0, 1, 16'h00AA, 0);
        applyStimulus(0, 0, 1, 16'h00BB, 0);
        applyStimulus(0, 1, 1, 16'h00CC, 0);
        checkOutput("flush_occupancy", {30'd0, occupancy}, 32'd0);
        checkOutput("flush_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("flush_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("flush_pipeline_out", {16'd0, pipeline_out}, 32'h00AA);
        applyStimulus(0, 0, 0, 16'h0000, 1);
        checkOutput("flush_idle_pipeline_out", {16'd0, pipeline_out}, 32'h00AA);

        // Narrow counter wraps: 1,2,3,0,1.
        cnt_seq[0] = 2'd1; cnt_seq[1] = 2'd2; cnt_seq[2] = 2'd3; cnt_seq[3] = 2'd0; cnt_seq[4] = 2'd1;
        applyStimulus(1, 0, 0, 16'h0000, 0);
        applyStimulus(0, 0, 1, 16'h0101, 1);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(0, 0, (k < 4), 16'h0102 + 16'(k), 1);
            checkOutput("wrap_xfer_count_w2", {30'd0, xfer_count2}, {30'd0, cnt_seq[k]});
        end

        // Reset wins over flush and handshakes in FULL.
        applyStimulus(0, 0, 1, 16'h0011, 0);
        applyStimulus(0, 0, 1, 16'h0022, 0);
        checkOutput("prereset_occupancy", {30'd0, occupancy}, 32'd2);
        applyStimulus(1, 1, 1, 16'h0033, 1);
        checkOutput("rstflush_pipeline_out", {16'd0, pipeline_out}, 32'd0);
        checkOutput("rstflush_xfer_count", {24'd0, xfer_count}, 32'd0);
        checkOutput("rstflush_occupancy", {30'd0, occupancy}, 32'd0);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            applyStimulus(($urandom_range(199) == 0), ($urandom_range(29) == 0),
                          ($urandom_range(3) != 0), 16'($urandom),
                          ($urandom_range(2) != 0));
        end
        applyStimulus(0, 0, 0, 16'h0000, 1);
        applyStimulus(0, 0, 0, 16'h0000, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
